pipe_reg_file: RTL

- Parametrised register file for the 16-bit pipelined CPU and its successors.
- Generalises the 4-entry, 2-read-port file to configurable data width, register count and read-port count.
- Adds same-cycle write-to-read bypass, so the pipeline needs no NOP padding for writeback hazards.
- Adds a per-register busy scoreboard, so ID can stall on outstanding multi-cycle writes such as loads.
- Sits between ID (reads, reservations) and WB (writes).

---
 rtl/pipe_reg_file_pkg.sv | 13 +
 rtl/pipe_reg_file_if.sv | 33 +++
 rtl/pipe_reg_file_rd.sv | 43 ++++
 rtl/pipe_reg_file.sv | 82 ++++++++
 4 files changed

// File: rtl/pipe_reg_file_pkg.sv
// Shared defaults, address-width helper and zero-register constant for the
// parametrised register file.
package rf_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_NREGS  = 4;
   localparam int ZERO_REG   = 0;

   function automatic int addr_w(input int nregs);
      return $clog2(nregs);
   endfunction

endpackage

// File: rtl/pipe_reg_file_if.sv
// Register-file bus between ID (reads, reservations), WB (writes) and the file.
// master = pipeline side, slave = register file.
interface rf_if
   import rf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   parameter int NRD    = 2
);
   localparam int ADDR_W = addr_w(NREGS);

   logic [NRD*ADDR_W-1:0] rr;
   logic [NRD*DATA_W-1:0] rd;
   logic [NRD-1:0]        rd_busy;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  rsv_en;
   logic [ADDR_W-1:0]     rsv_addr;
   logic [ADDR_W:0]       busy_cnt;
   logic                  sb_err;

   modport master (
      output rr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd, rd_busy, busy_cnt, sb_err
   );

   modport slave (
      input  rr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd, rd_busy, busy_cnt, sb_err
   );

endinterface

// File: rtl/pipe_reg_file_rd.sv
// One combinational read port: storage mux, busy lookup and, when
// RF_BYPASS_EN is defined, same-cycle writeback forwarding.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   localparam int ADDR_W = addr_w(NREGS)
) (
   input  logic [ADDR_W-1:0]             addr,
   input  logic [NREGS-1:0][DATA_W-1:0]  regs,
   input  logic [NREGS-1:0]              busy,
   input  logic                          wr_en,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic [DATA_W-1:0]             rd,
   output logic                          rd_busy
);

   logic is_zero;
   assign is_zero = (addr == ADDR_W'(ZERO_REG));

`ifdef RF_BYPASS_EN
   always_comb begin
      rd      = is_zero ? '0 : regs[addr];
      rd_busy = is_zero ? 1'b0 : busy[addr];
      // wr_en arrives already qualified against register 0 and reset
      if (wr_en && (wr_addr == addr)) begin
         rd      = wr_data;
         rd_busy = 1'b0;
      end
   end
`else
   logic unused_byp;
   assign unused_byp = ^{wr_en, wr_addr, wr_data};

   always_comb begin
      rd      = is_zero ? '0 : regs[addr];
      rd_busy = is_zero ? 1'b0 : busy[addr];
   end
`endif

endmodule

// File: rtl/pipe_reg_file.sv
// Parametrised register file with busy scoreboard and sticky WAW error.
// Define RF_BYPASS_EN to forward the WB write to same-cycle reads.
module pipe_reg_file
   import rf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   parameter int NRD    = 2
) (
   input logic clock,
   input logic reset,
   rf_if.slave bus
);

   localparam int ADDR_W = addr_w(NREGS);
   localparam int CNT_W  = ADDR_W + 1;

   logic [NREGS-1:0][DATA_W-1:0] regs;
   logic [NREGS-1:0]             busy;
   logic [NREGS-1:0]             busy_nxt;
   logic [CNT_W-1:0]             cnt_q;
   logic                         err_q;
   logic                         wr_hit;
   logic                         rsv_hit;
   logic                         waw;
   logic                         byp_en;

   function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NREGS; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   assign wr_hit  = bus.wr_en  && (bus.wr_addr  != ADDR_W'(ZERO_REG));
   assign rsv_hit = bus.rsv_en && (bus.rsv_addr != ADDR_W'(ZERO_REG));
   assign byp_en  = wr_hit && !reset;

   // A reservation on a busy register is only legal when WB retires it on the same edge
   assign waw = rsv_hit && busy[bus.rsv_addr] &&
                !(wr_hit && (bus.wr_addr == bus.rsv_addr));

   always_comb begin
      busy_nxt = busy;
      if (wr_hit)  busy_nxt[bus.wr_addr]  = 1'b0;
      if (rsv_hit) busy_nxt[bus.rsv_addr] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regs  <= '0;
         busy  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (wr_hit) regs[bus.wr_addr] <= bus.wr_data;
         busy  <= busy_nxt;
         cnt_q <= popcount(busy_nxt);
         if (waw) err_q <= 1'b1;
      end
   end

   assign bus.busy_cnt = cnt_q;
   assign bus.sb_err   = err_q;

   for (genvar p = 0; p < NRD; p++) begin : g_port
      rf_read_port #(
         .DATA_W (DATA_W),
         .NREGS  (NREGS)
      ) u_port (
         .addr    (bus.rr[p*ADDR_W +: ADDR_W]),
         .regs    (regs),
         .busy    (busy),
         .wr_en   (byp_en),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .rd      (bus.rd[p*DATA_W +: DATA_W]),
         .rd_busy (bus.rd_busy[p])
      );
   end

endmodule
